// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: command, serial and status signals of the universal shift register
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int AW = $clog2(WIDTH)
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] data;
  logic             sin_r;
  logic             sin_l;
  logic             start;
  logic [AW-1:0]    amount;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;
  modport master (
    output en, mode, data, sin_r, sin_l, start, amount,
    input  q, sout_l, sout_r, busy, done
  );
  modport slave (
    input  en, mode, data, sin_r, sin_l, start, amount,
    output q, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with single-step ops and multi-step bursts
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  univ_shift_reg_if.slave bus
);
  logic [WIDTH-1:0] r_q;
  logic             r_busy;
  logic             r_done;
  logic [AW-1:0]    r_cnt;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode;
  logic [WIDTH-1:0] w_next;
  logic             w_shift;
  logic             w_long;
  always_comb begin
    w_mode  = r_busy ? r_mode : bus.mode;
    w_next  = r_q;
    case (w_mode)
      3'b001:  w_next = bus.data;
      3'b010:  w_next = {r_q[WIDTH-2:0], bus.sin_r};
      3'b011:  w_next = {bus.sin_l, r_q[WIDTH-1:1]};
      3'b100:  w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      3'b101:  w_next = {r_q[0], r_q[WIDTH-1:1]};
      3'b110:  w_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      3'b111:  w_next = '0;
      default: w_next = r_q;
    endcase
    w_shift = (bus.mode >= 3'b010) && (bus.mode <= 3'b110);
    w_long  = w_shift && (bus.amount > AW'(1));
  end
  // the counter holds steps still to go after the current edge; the last one raises done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_mode <= 3'b000;
    end else if (r_busy) begin
      r_q    <= w_next;
      r_cnt  <= r_cnt - 1'b1;
      r_busy <= r_cnt != AW'(1);
      r_done <= r_cnt == AW'(1);
    end else if (bus.start) begin
      r_q    <= (w_shift && bus.amount == '0) ? r_q : w_next;
      r_mode <= bus.mode;
      r_cnt  <= w_long ? bus.amount - 1'b1 : '0;
      r_busy <= w_long;
      r_done <= !w_long;
    end else begin
      if (bus.en) r_q <= w_next;
      r_done <= 1'b0;
    end
  end
  assign bus.q      = r_q;
  assign bus.sout_l = r_q[WIDTH-1];
  assign bus.sout_r = r_q[0];
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed and randomized checks against a remaining-steps reference model
module tb_univ_shift_reg;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_errors = 0;
  univ_shift_reg_if #(.WIDTH(W)) bus ();
  univ_shift_reg #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [W-1:0] m_q = '0;
  logic [2:0]   m_mode = '0;
  int           m_rem = 0;
  bit           m_done = 1'b0;
  int           n;
  function automatic logic [W-1:0] step(logic [2:0] m, logic [W-1:0] v);
    int x, mask, top;
    x = int'(v);
    mask = (1 << W) - 1;
    top = 1 << (W - 1);
    case (m)
      3'd1:    x = int'(bus.data);
      3'd2:    x = ((x << 1) | int'(bus.sin_r)) & mask;
      3'd3:    x = (x >> 1) | (int'(bus.sin_l) * top);
      3'd4:    x = ((x << 1) | (x >> (W - 1))) & mask;
      3'd5:    x = (x >> 1) | ((x & 1) * top);
      3'd6:    x = (x >> 1) | (x & top);
      3'd7:    x = 0;
      default: x = x;
    endcase
    return W'(x);
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_q = '0; m_rem = 0; m_done = 0; m_mode = '0;
    end else if (m_rem > 0) begin
      m_q = step(m_mode, m_q);
      m_rem--;
      m_done = (m_rem == 0);
    end else if (bus.start) begin
      n = (bus.mode inside {[3'd2:3'd6]}) ? int'(bus.amount) : 1;
      if (n > 0) m_q = step(bus.mode, m_q);
      m_rem = (n > 0) ? n - 1 : 0;
      m_mode = bus.mode;
      m_done = (m_rem == 0);
    end else begin
      if (bus.en) m_q = step(bus.mode, m_q);
      m_done = 0;
    end
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    chk("q", 32'(bus.q), 32'(m_q));
    chk("busy", 32'(bus.busy), 32'(m_rem > 0));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("sout_l", 32'(bus.sout_l), 32'(m_q[W-1]));
    chk("sout_r", 32'(bus.sout_r), 32'(m_q[0]));
  endtask
  task automatic lit(string nm, logic [31:0] act, logic [31:0] mdl, logic [31:0] exp);
    chk(nm, act, exp);
    chk({"model_", nm}, mdl, exp);
  endtask
  initial begin
    rst = 1'b1;
    bus.en = 0; bus.mode = 0; bus.data = 0; bus.sin_r = 0; bus.sin_l = 0;
    bus.start = 0; bus.amount = 0;
    @(negedge clk);
    tick();
    lit("rst_q", 32'(bus.q), 32'(m_q), 32'h0);
    lit("rst_busy", 32'(bus.busy), 32'(m_rem > 0), 0);
    lit("rst_done", 32'(bus.done), 32'(m_done), 0);
    rst = 1'b0;
    bus.en = 1; bus.mode = 3'b001; bus.data = 8'hA5; tick();
    bus.mode = 3'b100; tick();
    bus.en = 0;
    lit("rol_q", 32'(bus.q), 32'(m_q), 32'h4B);
    lit("rol_sout_l", 32'(bus.sout_l), 32'(m_q[W-1]), 0);
    bus.en = 1; bus.mode = 3'b001; bus.data = 8'h81; tick();
    bus.en = 0; bus.start = 1; bus.mode = 3'b110; bus.amount = 3; tick();
    bus.start = 0;
    lit("asr_busy1", 32'(bus.busy), 32'(m_rem > 0), 1);
    tick();
    lit("asr_busy2", 32'(bus.busy), 32'(m_rem > 0), 1);
    tick();
    lit("asr_busy3", 32'(bus.busy), 32'(m_rem > 0), 0);
    lit("asr_done", 32'(bus.done), 32'(m_done), 1);
    lit("asr_q", 32'(bus.q), 32'(m_q), 32'hF0);
    tick();
    lit("asr_done_after", 32'(bus.done), 32'(m_done), 0);
    bus.en = 1; bus.mode = 3'b001; bus.data = 8'h01; tick();
    bus.en = 0; bus.sin_r = 1; bus.start = 1; bus.mode = 3'b010; bus.amount = 4; tick();
    bus.start = 0; bus.mode = 3'b001; bus.data = 8'hFF; bus.en = 1; tick();
    bus.start = 1; bus.amount = 7; tick();
    tick();
    lit("shl_q", 32'(bus.q), 32'(m_q), 32'h1F);
    lit("shl_done", 32'(bus.done), 32'(m_done), 1);
    bus.en = 0; bus.start = 0; bus.mode = 3'b000; tick();
    lit("shl_done_after", 32'(bus.done), 32'(m_done), 0);
    lit("shl_hold_q", 32'(bus.q), 32'(m_q), 32'h1F);
    bus.start = 1; bus.mode = 3'b010; bus.amount = 0; tick();
    bus.start = 0;
    lit("amt0_q", 32'(bus.q), 32'(m_q), 32'h1F);
    lit("amt0_busy", 32'(bus.busy), 32'(m_rem > 0), 0);
    lit("amt0_done", 32'(bus.done), 32'(m_done), 1);
    tick();
    lit("amt0_done_after", 32'(bus.done), 32'(m_done), 0);
    bus.start = 1; bus.mode = 3'b100; bus.amount = 5; tick();
    bus.start = 0; tick();
    lit("abort_busy_pre", 32'(bus.busy), 32'(m_rem > 0), 1);
    rst = 1; tick();
    rst = 0;
    lit("abort_q", 32'(bus.q), 32'(m_q), 32'h0);
    lit("abort_busy", 32'(bus.busy), 32'(m_rem > 0), 0);
    lit("abort_done", 32'(bus.done), 32'(m_done), 0);
    bus.start = 1; bus.en = 1; bus.mode = 3'b001; bus.data = 8'h3C; tick();
    bus.start = 0; bus.en = 0;
    lit("ld_q", 32'(bus.q), 32'(m_q), 32'h3C);
    lit("ld_done", 32'(bus.done), 32'(m_done), 1);
    lit("ld_busy", 32'(bus.busy), 32'(m_rem > 0), 0);
    tick();
    lit("ld_done_after", 32'(bus.done), 32'(m_done), 0);
    lit("ld_hold_q", 32'(bus.q), 32'(m_q), 32'h3C);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.en = 1'($urandom);
      bus.mode = 3'($urandom);
      bus.data = W'($urandom);
      bus.sin_r = 1'($urandom);
      bus.sin_l = 1'($urandom);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.amount = 3'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
